pipe_ctrl: RTL and testbench

Parametrised pipeline sequencer for the in-order core. It owns one valid bit per stage, the PC and pipeline-register load enables, and the bubble, flush and hold rules that are currently spread across the fixed five-stage register modules. Stage count, stall point and branch-resolve point are parameters. It also adds retire tracking and stall/flush event counters.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_perf_cnt.sv | 36 +++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline sequencer and its counters.
// No logic; combinational helpers only.
// No flow control of its own.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ACT_ADV   = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_HOLD  = 2'd3
    } action_t;

    localparam int DEF_STAGES        = 5;
    localparam int DEF_STALL_STAGE   = 1;
    localparam int DEF_RESOLVE_STAGE = 2;
    localparam int DEF_CNT_W         = 32;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle, retire, stall and flush event counters, wrapping modulo 2^CNT_W.
// Counts appear one cycle after the event; no flow control.
// Never stalls; counts every non-reset cycle.
import pipe_ctrl_pkg::*;

module pipe_perf_cnt #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  action_t          act,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (retire)
                inst_count <= inst_count + 1'b1;
            if (act == ACT_STALL)
                stall_count <= stall_count + 1'b1;
            if (act == ACT_FLUSH)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage valids, PC/stage load enables, hold/flush/stall; counters under PIPE_CTRL_PERF_EN.
// Enables and retire are combinational from inputs and registered valids; valids update each edge.
// ext_hold_i freezes everything; a stall freezes stages up to STALL_STAGE and inserts a bubble behind it.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int STAGES        = DEF_STAGES,
    parameter int STALL_STAGE   = DEF_STALL_STAGE,
    parameter int RESOLVE_STAGE = DEF_RESOLVE_STAGE,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid_i,
    input  logic              stall_req_i,
    input  logic              flush_req_i,
    input  logic              ext_hold_i,
    output logic              pc_en_o,
    output logic [STAGES-2:0] stage_en_o,
    output logic [STAGES-1:0] stage_valid_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  inst_count_o,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    if (!(0 < STALL_STAGE && STALL_STAGE < RESOLVE_STAGE && RESOLVE_STAGE < STAGES-1)) begin : g_bad_cfg
        $error("pipe_ctrl: need 0 < STALL_STAGE < RESOLVE_STAGE < STAGES-1");
    end

    // Stages 0..STALL_STAGE hold during a stall; the slot behind them becomes a bubble.
    localparam logic [STAGES-1:0] STALL_KEEP =
        {{(STAGES-STALL_STAGE-1){1'b0}}, {(STALL_STAGE+1){1'b1}}};
    localparam logic [STAGES-1:0] STALL_BUBBLE = STALL_KEEP ^ {STALL_KEEP[STAGES-2:0], 1'b1};
    // Younger instructions between IF and the branch are killed on a flush.
    localparam logic [STAGES-1:0] FLUSH_KILL =
        {{(STAGES-RESOLVE_STAGE-1){1'b0}}, {RESOLVE_STAGE{1'b1}}, 1'b0};

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_nxt;
    logic [STAGES-1:0] valid_shift;
    action_t           act;
    logic              adv_like;

    always_comb begin
        act = ACT_ADV;
        if (ext_hold_i)
            act = ACT_HOLD;
        else if (flush_req_i && valid_q[RESOLVE_STAGE])
            act = ACT_FLUSH;
        else if (stall_req_i && valid_q[STALL_STAGE])
            act = ACT_STALL;
    end

    assign adv_like    = (act == ACT_ADV) || (act == ACT_FLUSH);
    assign valid_shift = {valid_q[STAGES-2:0], fetch_valid_i};

    always_comb begin
        valid_nxt = valid_q;
        case (act)
            ACT_ADV:   valid_nxt = valid_shift;
            ACT_FLUSH: begin
                valid_nxt = valid_shift & ~FLUSH_KILL;
                valid_nxt[RESOLVE_STAGE+1] = 1'b1;
            end
            ACT_STALL: valid_nxt = (valid_q & STALL_KEEP) | (valid_shift & ~STALL_KEEP & ~STALL_BUBBLE);
            default:   valid_nxt = valid_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else
            valid_q <= valid_nxt;
    end

    assign stage_valid_o = valid_q;
    assign pc_en_o       = !rst && adv_like;
    assign retire_o      = valid_q[STAGES-1] && !ext_hold_i && !rst;

    for (genvar g = 0; g < STAGES-1; g++) begin : g_stage_en
        if (g < STALL_STAGE) begin : g_front
            assign stage_en_o[g] = !rst && adv_like;
        end else begin : g_back
            assign stage_en_o[g] = !rst && (act != ACT_HOLD);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .act         (act),
        .retire      (retire_o),
        .cycle_count (cycle_count_o),
        .inst_count  (inst_count_o),
        .stall_count (stall_count_o),
        .flush_count (flush_count_o)
    );
`else
    assign cycle_count_o = '0;
    assign inst_count_o  = '0;
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against an instruction-id pipeline model.
module tb_pipe_ctrl;

    localparam int N  = 5;
    localparam int SS = 1;
    localparam int RS = 2;
    localparam int CW = 8;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid_i;
    logic          stall_req_i;
    logic          flush_req_i;
    logic          ext_hold_i;
    logic          pc_en_o;
    logic [N-2:0]  stage_en_o;
    logic [N-1:0]  stage_valid_o;
    logic          retire_o;
    logic [CW-1:0] cycle_count_o;
    logic [CW-1:0] inst_count_o;
    logic [CW-1:0] stall_count_o;
    logic [CW-1:0] flush_count_o;

    pipe_ctrl #(
        .STAGES        (N),
        .STALL_STAGE   (SS),
        .RESOLVE_STAGE (RS),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .stall_req_i   (stall_req_i),
        .flush_req_i   (flush_req_i),
        .ext_hold_i    (ext_hold_i),
        .pc_en_o       (pc_en_o),
        .stage_en_o    (stage_en_o),
        .stage_valid_o (stage_valid_o),
        .retire_o      (retire_o),
        .cycle_count_o (cycle_count_o),
        .inst_count_o  (inst_count_o),
        .stall_count_o (stall_count_o),
        .flush_count_o (flush_count_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: instruction id held by each stage, 0 meaning empty.
    int pipe [N];
    int next_id;
    int m_cyc, m_inst, m_stall, m_flush;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cnt_exp(input int v);
        return PERF ? 64'(v % (1 << CW)) : 64'd0;
    endfunction

    task automatic step(input bit f, input bit s, input bit fl, input bit h, input bit r);
        bit           do_flush;
        bit           do_stall;
        bit           ret;
        logic [N-1:0] ev;
        logic [N-2:0] ee;
        @(negedge clk);
        fetch_valid_i = f;
        stall_req_i   = s;
        flush_req_i   = fl;
        ext_hold_i    = h;
        rst           = r;
        #1;
        do_flush = !h && fl && (pipe[RS] != 0);
        do_stall = !h && !do_flush && s && (pipe[SS] != 0);
        ret      = (pipe[N-1] != 0) && !h && !r;
        for (int i = 0; i < N; i++)
            ev[i] = (pipe[i] != 0);
        for (int i = 0; i < N-1; i++)
            ee[i] = !r && !h && !(do_stall && i < SS);
        chk("valid",     stage_valid_o, ev);
        chk("pc_en",     pc_en_o, !r && !h && !do_stall);
        chk("stage_en",  stage_en_o, ee);
        chk("retire",    retire_o, ret);
        chk("cycle_cnt", cycle_count_o, cnt_exp(m_cyc));
        chk("inst_cnt",  inst_count_o, cnt_exp(m_inst));
        chk("stall_cnt", stall_count_o, cnt_exp(m_stall));
        chk("flush_cnt", flush_count_o, cnt_exp(m_flush));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) pipe[i] = 0;
            m_cyc = 0; m_inst = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_cyc++;
            if (ret)      m_inst++;
            if (do_stall) m_stall++;
            if (do_flush) m_flush++;
            if (h) begin
                // frozen
            end else if (do_stall) begin
                for (int i = N-1; i > SS+1; i--) pipe[i] = pipe[i-1];
                pipe[SS+1] = 0;
            end else begin
                for (int i = N-1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = 0;
                if (f) begin
                    pipe[0] = next_id;
                    next_id++;
                end
                if (do_flush)
                    for (int i = 1; i <= RS; i++) pipe[i] = 0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] fill_exp;
        rst = 1'b1; fetch_valid_i = 1'b0; stall_req_i = 1'b0;
        flush_req_i = 1'b0; ext_hold_i = 1'b0;
        for (int i = 0; i < N; i++) pipe[i] = 0;
        next_id = 1; m_cyc = 0; m_inst = 0; m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);

        // Fill: valids grow one stage per edge.
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, 0, 0, 0);
            if (k <= N) begin
                fill_exp = '0;
                for (int j = 0; j < k; j++) fill_exp[j] = 1'b1;
                #2 chk("fill_pattern", stage_valid_o, fill_exp);
            end
        end

        // Load-use stall in a full pipe, then recover.
        step(1, 1, 0, 0, 0);
        #2 chk("stall_bubble", stage_valid_o[SS+1], 1'b0);
        repeat (4) step(1, 0, 0, 0, 0);

        // Branch flush in a full pipe.
        step(1, 0, 1, 0, 0);
        #2 chk("flush_pattern", stage_valid_o, 5'b11001);
        repeat (4) step(1, 0, 0, 0, 0);

        // Flush and stall together, then hold with both.
        step(1, 1, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        #2 chk("hold_both_frozen", stage_valid_o, 5'b11111);

        // Three hold cycles in a full pipe.
        repeat (3) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);

        // Reset with a full pipe.
        step(1, 0, 0, 0, 1);
        #2 chk("rst_clear", stage_valid_o, 5'b00000);

        // Long randomized run; counters wrap past 2^CW before the mid-run reset.
        for (int i = 0; i < 700; i++)
            step($urandom_range(9) < 8, $urandom_range(4) == 0, $urandom_range(9) == 0,
                 $urandom_range(9) == 0, i == 400);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
